mem_pipe: RTL and testbench
===========================

# mem_pipe

Parametrised memory-access stage with MEM/WB pipeline register, placed between execute and writeback. Adds byte/half/word accesses with lane alignment and sign/zero extension, byte enables, a miss-wait FSM that stalls upstream on `d_miss`, misalignment detection, and a saturating miss-cycle counter. It supersedes the fixed-width word-only stage.

## Interface
Parameters:
- `TRD_NUM`, 8: hardware threads; `TRD_W = $clog2(TRD_NUM)`
- `REG_W`, 5: register-index width
- `PERF_W`, 16: miss-cycle counter width

Ports:
- `clk`  in  1  clock; one clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `valid_mem`  in  1  instruction in MEM is valid
- `d_addr_mem`, `ins_mem`, `pc_mem`, `exe_data_mem`  in  32 each  address, instruction, PC, ALU result/store data
- `trd_mem`, `obj_trd_mem`  in  TRD_W  owning thread, target thread
- `reg_wr_mem`  in  REG_W  destination register
- `wr_en_mem`, `wb_sel_mem`  in  1  register write enable, WB mux select
- `mem_ctrl_mem`  in  2  01 read, 10 write, 00 none; 11 illegal, treated as none
- `mem_size_mem`  in  2  00 byte, 01 half, 10 word; 11 treated as word
- `mem_sext_mem`  in  1  sign-extend loads
- `trd_ctrl_mem`  in  2  thread control, passed through
- `flushMEM`  in  1  synchronous flush
- `d_miss`  in  1  dcache miss, valid in the cycle a request is driven
- `d_rd_data`  in  32  read data, valid when `d_rd` and not `d_miss`
- `d_rd`, `d_wr`  out  1  memory strobes
- `d_addr`  out  32  word-aligned address: `{d_addr_mem[31:2],2'b00}`
- `d_be`  out  4  byte enables
- `d_wr_data`  out  32  lane-replicated store data
- `stall_mem`  out  1  upstream must hold MEM inputs
- `valid_wb`, `ins_wb`, `pc_wb`, `exe_data_wb`, `rd_data_wb`, `trd_wb`, `reg_wr_wb`, `wr_en_wb`, `trd_ctrl_wb`, `obj_trd_wb`, `wb_sel_wb`  out  widths as above; `rd_data_wb` is 32 bits
- `misalign_wb`  out  1  exception flag for the WB instruction
- `miss_cycles`  out  PERF_W  saturating count of cycles spent in MISS

## Operation
- Request: `req = valid_mem & mem_ctrl ∈ {01,10} & ~misalign & ~flushMEM`. Misalign: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- `d_rd`/`d_wr` = req gated by type. All other memory outputs are combinational from MEM inputs.
- `d_be`: byte `4'b0001<<addr[1:0]`; half `addr[1]?1100:0011`; word `1111`. Zero when no request.
- `d_wr_data`: byte `{4{data[7:0]}}`, half `{2{data[15:0]}}`, word `data`.
- Load extract: select lane by `addr[1:0]` and size, then zero- or sign-extend per `mem_sext_mem`.
- FSM states IDLE and MISS:
  - IDLE, req & `d_miss`: go to MISS. `stall_mem`=1 and WB receives a bubble.
  - MISS, `d_miss`=1: stay. `stall_mem`=1, request held on the bus, bubble to WB.
  - MISS, `d_miss`=0: register the result into WB, `stall_mem`=0, go to IDLE.
  - `flushMEM` in any state: go to IDLE. Strobes are 0 that cycle, WB receives a bubble, the request is abandoned.
- Bubble: all `*_wb` outputs are 0.
- Misaligned valid access: no strobes. WB gets the instruction with `misalign_wb`=1 and `wr_en_wb`=0.
- `miss_cycles` increments every cycle in MISS and saturates at all-ones.

## Timing
- Async reset: all outputs 0, FSM in IDLE, counter 0.
- Hit: WB outputs update at the clock edge after the request cycle (1-cycle latency).
- Miss lasting N cycles of `d_miss`=1: `stall_mem` is high for those N cycles, and the result appears in WB at edge N+1.
- Flush has priority over miss completion and over reset release; the reset path is separate from the flush path.
- `valid_mem`=0: bubble to WB, FSM unchanged while in IDLE.

## Structure
- Package `mem_pkg`:
  - `mem_ctrl_e` (NONE, RD, WR)
  - `mem_size_e` (BYTE, HALF, WORD)
  - `mem_state_e` (IDLE, MISS)
- Sub-module `mem_lane`: combinational byte-enable, store replication, and load extract/extend.

## Test plan
- Word load to 0x100, `d_rd_data`=0xDEADBEEF, hit → next cycle `rd_data_wb`=0xDEADBEEF, `valid_wb`=1, `d_be`=1111.
- Signed byte load to 0x103, data 0x80xxxxxx → `rd_data_wb`=0xFFFFFF80. Unsigned → 0x00000080.
- Half store 0xABCD to 0x202 → `d_be`=1100, `d_wr_data`=0xABCDABCD, `d_wr`=1.
- Load with `d_miss` high 3 cycles → `stall_mem` high 3 cycles, 3 bubbles, result at edge 4, `miss_cycles`=3.
- `flushMEM` during the 2nd miss cycle → strobes drop that cycle, next state IDLE, bubble, no WB result.
- Word load to 0x102 → no strobe, `misalign_wb`=1, `wr_en_wb`=0. Async reset mid-MISS → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: access kind, access size and miss-wait state encodings.
package mem_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_pipe_if.sv
// Data-cache bus between the MEM stage (master) and the cache (slave).
interface mem_pipe_if;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wr_data;
  logic        d_miss;
  logic [31:0] d_rd_data;

  modport master (
    output d_rd, d_wr, d_addr, d_be, d_wr_data,
    input  d_miss, d_rd_data
  );

  modport slave (
    input  d_rd, d_wr, d_addr, d_be, d_wr_data,
    output d_miss, d_rd_data
  );
endinterface

// File: rtl/mem_lane.sv
// Lane logic: byte enables, store-data replication, load lane select with sign/zero extension.
// Purely combinational; size 11 behaves as word.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_rep,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
  end

  always_comb begin
    be      = 4'hF;
    st_rep  = st_data;
    ld_data = ld_raw;
    case (size)
      BYTE: begin
        be      = 4'b0001 << addr_lo;
        st_rep  = {4{st_data[7:0]}};
        ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
      end
      HALF: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_rep  = {2{st_data[15:0]}};
        ld_data = {{16{sext & ld_half[15]}}, ld_half};
      end
      default: begin
        be      = 4'hF;
        st_rep  = st_data;
        ld_data = ld_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_pipe.sv
// MEM stage with MEM/WB register: 1-cycle hit latency, stalls upstream while the dcache reports a miss.
// Flush abandons any pending request and inserts a bubble.
module mem_pipe
  import mem_pkg::*;
#(
  parameter  int TRD_NUM = 8,
  parameter  int REG_W   = 5,
  parameter  int PERF_W  = 16,
  localparam int TRD_W   = $clog2(TRD_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_mem,
  input  logic [31:0]       d_addr_mem,
  input  logic [31:0]       ins_mem,
  input  logic [31:0]       pc_mem,
  input  logic [31:0]       exe_data_mem,
  input  logic [TRD_W-1:0]  trd_mem,
  input  logic [TRD_W-1:0]  obj_trd_mem,
  input  logic [REG_W-1:0]  reg_wr_mem,
  input  logic              wr_en_mem,
  input  logic              wb_sel_mem,
  input  logic [1:0]        mem_ctrl_mem,
  input  logic [1:0]        mem_size_mem,
  input  logic              mem_sext_mem,
  input  logic [1:0]        trd_ctrl_mem,
  input  logic              flushMEM,
  mem_pipe_if.master        dbus,
  output logic              stall_mem,
  output logic              valid_wb,
  output logic [31:0]       ins_wb,
  output logic [31:0]       pc_wb,
  output logic [31:0]       exe_data_wb,
  output logic [31:0]       rd_data_wb,
  output logic [TRD_W-1:0]  trd_wb,
  output logic [REG_W-1:0]  reg_wr_wb,
  output logic              wr_en_wb,
  output logic [1:0]        trd_ctrl_wb,
  output logic [TRD_W-1:0]  obj_trd_wb,
  output logic              wb_sel_wb,
  output logic              misalign_wb,
  output logic [PERF_W-1:0] miss_cycles
);

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_MISS = 1'(MISS);

  logic [0:0]  state, state_nxt;
  logic        is_rd, is_wr, is_acc, misalign, req, in_miss, capture;
  logic [3:0]  lane_be;
  logic [31:0] lane_st, lane_ld;

  mem_lane u_lane (
    .addr_lo (d_addr_mem[1:0]),
    .size    (mem_size_mem),
    .sext    (mem_sext_mem),
    .st_data (exe_data_mem),
    .ld_raw  (dbus.d_rd_data),
    .be      (lane_be),
    .st_rep  (lane_st),
    .ld_data (lane_ld)
  );

  assign is_rd    = (mem_ctrl_mem == RD);
  assign is_wr    = (mem_ctrl_mem == WR);
  assign is_acc   = is_rd | is_wr;
  // Size 11 aliases word, so bit 1 alone marks a word-sized access.
  assign misalign = is_acc & (((mem_size_mem == HALF) & d_addr_mem[0]) |
                              (mem_size_mem[1] & (d_addr_mem[1:0] != 2'b00)));
  assign req      = rst_n & valid_mem & is_acc & ~misalign & ~flushMEM;
  assign in_miss  = (state == ST_MISS);

  assign dbus.d_rd      = req & is_rd;
  assign dbus.d_wr      = req & is_wr;
  assign dbus.d_be      = req ? lane_be : 4'h0;
  assign dbus.d_addr    = rst_n ? {d_addr_mem[31:2], 2'b00} : 32'h0;
  assign dbus.d_wr_data = rst_n ? lane_st : 32'h0;

  assign stall_mem = rst_n & ~flushMEM & dbus.d_miss & (in_miss | req);
  // Upstream holds its inputs during a miss, so completion captures the same instruction.
  assign capture   = rst_n & ~flushMEM & valid_mem &
                     (in_miss ? ~dbus.d_miss : ~(req & dbus.d_miss));

  always_comb begin
    state_nxt = state;
    if (flushMEM)                      state_nxt = ST_IDLE;
    else if (!in_miss && req && dbus.d_miss) state_nxt = ST_MISS;
    else if (in_miss && !dbus.d_miss)  state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      miss_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (in_miss && (miss_cycles != {PERF_W{1'b1}}))
        miss_cycles <= miss_cycles + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !capture) begin
      valid_wb    <= 1'b0;
      ins_wb      <= '0;
      pc_wb       <= '0;
      exe_data_wb <= '0;
      rd_data_wb  <= '0;
      trd_wb      <= '0;
      reg_wr_wb   <= '0;
      wr_en_wb    <= 1'b0;
      trd_ctrl_wb <= '0;
      obj_trd_wb  <= '0;
      wb_sel_wb   <= 1'b0;
      misalign_wb <= 1'b0;
    end else begin
      valid_wb    <= 1'b1;
      ins_wb      <= ins_mem;
      pc_wb       <= pc_mem;
      exe_data_wb <= exe_data_mem;
      rd_data_wb  <= (is_rd && !misalign) ? lane_ld : 32'h0;
      trd_wb      <= trd_mem;
      reg_wr_wb   <= reg_wr_mem;
      wr_en_wb    <= wr_en_mem & ~misalign;
      trd_ctrl_wb <= trd_ctrl_mem;
      obj_trd_wb  <= obj_trd_mem;
      wb_sel_wb   <= wb_sel_mem;
      misalign_wb <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe: hits, lane handling, miss stall, flush, misalign, counter saturation, async reset.
module tb_mem_pipe;
  import mem_pkg::*;

  localparam int TRD_W  = 3;
  localparam int REG_W  = 5;
  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_mem;
  logic [31:0]       d_addr_mem, ins_mem, pc_mem, exe_data_mem;
  logic [TRD_W-1:0]  trd_mem, obj_trd_mem;
  logic [REG_W-1:0]  reg_wr_mem;
  logic              wr_en_mem, wb_sel_mem, mem_sext_mem, flushMEM;
  logic [1:0]        mem_ctrl_mem, mem_size_mem, trd_ctrl_mem;
  logic              stall_mem, valid_wb, wr_en_wb, wb_sel_wb, misalign_wb;
  logic [31:0]       ins_wb, pc_wb, exe_data_wb, rd_data_wb;
  logic [TRD_W-1:0]  trd_wb, obj_trd_wb;
  logic [REG_W-1:0]  reg_wr_wb;
  logic [1:0]        trd_ctrl_wb;
  logic [PERF_W-1:0] miss_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  mem_pipe_if dbus ();

  always #5 clk = ~clk;

  mem_pipe #(.TRD_NUM(8), .REG_W(REG_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem), .d_addr_mem(d_addr_mem),
    .ins_mem(ins_mem), .pc_mem(pc_mem), .exe_data_mem(exe_data_mem),
    .trd_mem(trd_mem), .obj_trd_mem(obj_trd_mem), .reg_wr_mem(reg_wr_mem),
    .wr_en_mem(wr_en_mem), .wb_sel_mem(wb_sel_mem), .mem_ctrl_mem(mem_ctrl_mem),
    .mem_size_mem(mem_size_mem), .mem_sext_mem(mem_sext_mem), .trd_ctrl_mem(trd_ctrl_mem),
    .flushMEM(flushMEM), .dbus(dbus), .stall_mem(stall_mem), .valid_wb(valid_wb),
    .ins_wb(ins_wb), .pc_wb(pc_wb), .exe_data_wb(exe_data_wb), .rd_data_wb(rd_data_wb),
    .trd_wb(trd_wb), .reg_wr_wb(reg_wr_wb), .wr_en_wb(wr_en_wb), .trd_ctrl_wb(trd_ctrl_wb),
    .obj_trd_wb(obj_trd_wb), .wb_sel_wb(wb_sel_wb), .misalign_wb(misalign_wb),
    .miss_cycles(miss_cycles)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    valid_mem = 0; d_addr_mem = 0; ins_mem = 0; pc_mem = 0; exe_data_mem = 0;
    trd_mem = 0; obj_trd_mem = 0; reg_wr_mem = 0; wr_en_mem = 0; wb_sel_mem = 0;
    mem_ctrl_mem = 2'b00; mem_size_mem = 2'b00; mem_sext_mem = 0; trd_ctrl_mem = 0;
    flushMEM = 0; dbus.d_miss = 0; dbus.d_rd_data = 0;
  endtask

  task automatic set_acc(input logic [1:0] ctrl, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] data);
    valid_mem = 1; mem_ctrl_mem = ctrl; mem_size_mem = size; mem_sext_mem = sext;
    d_addr_mem = addr; exe_data_mem = data; wr_en_mem = (ctrl == RD);
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_inputs();
    #12;
    n_tests++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL reset_valid_wb got %b want 0", valid_wb); end
    n_tests++; if (miss_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_miss_cycles got %0d want 0", miss_cycles); end
    n_tests++; if ({dbus.d_rd, dbus.d_wr, dbus.d_be, stall_mem} !== 7'b0) begin n_fail++; $display("FAIL reset_strobes got %b want 0", {dbus.d_rd, dbus.d_wr, dbus.d_be, stall_mem}); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_word_load;
    set_acc(RD, WORD, 0, 32'h100, 32'h0);
    ins_mem = 32'h1111_2222; pc_mem = 32'h40; reg_wr_mem = 5'd5; trd_mem = 3'd3;
    obj_trd_mem = 3'd6; trd_ctrl_mem = 2'b10; wb_sel_mem = 1; dbus.d_rd_data = 32'hDEADBEEF;
    #1;
    n_tests++; if (dbus.d_be !== 4'hF) begin n_fail++; $display("FAIL word_be got %h want f", dbus.d_be); end
    n_tests++; if ({dbus.d_rd, dbus.d_wr, stall_mem} !== 3'b100) begin n_fail++; $display("FAIL word_strobes got %b want 100", {dbus.d_rd, dbus.d_wr, stall_mem}); end
    n_tests++; if (dbus.d_addr !== 32'h100) begin n_fail++; $display("FAIL word_addr got %h want 100", dbus.d_addr); end
    tick();
    n_tests++; if (rd_data_wb !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd_data got %h want deadbeef", rd_data_wb); end
    n_tests++; if ({valid_wb, wr_en_wb, misalign_wb, wb_sel_wb} !== 4'b1101) begin n_fail++; $display("FAIL word_flags got %b want 1101", {valid_wb, wr_en_wb, misalign_wb, wb_sel_wb}); end
    n_tests++; if ({ins_wb, pc_wb, reg_wr_wb, trd_wb, obj_trd_wb, trd_ctrl_wb} !== {32'h1111_2222, 32'h40, 5'd5, 3'd3, 3'd6, 2'b10}) begin
      n_fail++; $display("FAIL word_passthru got %h/%h/%0d/%0d/%0d/%b", ins_wb, pc_wb, reg_wr_wb, trd_wb, obj_trd_wb, trd_ctrl_wb); end
    clear_inputs();
    tick();
    n_tests++; if ({valid_wb, ins_wb, rd_data_wb} !== 65'b0) begin n_fail++; $display("FAIL idle_bubble got %b/%h/%h want 0", valid_wb, ins_wb, rd_data_wb); end
  endtask

  task automatic test_byte_half_load;
    set_acc(RD, BYTE, 1, 32'h103, 32'h0);
    dbus.d_rd_data = 32'h8012_3456;
    #1;
    n_tests++; if ({dbus.d_be, dbus.d_addr} !== {4'b1000, 32'h100}) begin n_fail++; $display("FAIL byte_be_addr got %b/%h want 1000/100", dbus.d_be, dbus.d_addr); end
    tick();
    n_tests++; if (rd_data_wb !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_sext got %h want ffffff80", rd_data_wb); end
    mem_sext_mem = 0;
    tick();
    n_tests++; if (rd_data_wb !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_zext got %h want 00000080", rd_data_wb); end
    set_acc(RD, HALF, 1, 32'h102, 32'h0);
    tick();
    n_tests++; if (rd_data_wb !== 32'hFFFF_8012) begin n_fail++; $display("FAIL half_sext got %h want ffff8012", rd_data_wb); end
    set_acc(RD, BYTE, 1, 32'h101, 32'h0);
    tick();
    n_tests++; if (rd_data_wb !== 32'h0000_0034) begin n_fail++; $display("FAIL byte1_sext got %h want 00000034", rd_data_wb); end
    clear_inputs();
  endtask

  task automatic test_store;
    set_acc(WR, HALF, 0, 32'h202, 32'h1234_ABCD);
    #1;
    n_tests++; if ({dbus.d_be, dbus.d_wr_data} !== {4'b1100, 32'hABCD_ABCD}) begin n_fail++; $display("FAIL half_store got %b/%h want 1100/abcdabcd", dbus.d_be, dbus.d_wr_data); end
    n_tests++; if ({dbus.d_wr, dbus.d_rd, dbus.d_addr} !== {2'b10, 32'h200}) begin n_fail++; $display("FAIL half_store_strobe got %b%b/%h want 10/200", dbus.d_wr, dbus.d_rd, dbus.d_addr); end
    set_acc(WR, BYTE, 0, 32'h201, 32'h0000_00EF);
    #1;
    n_tests++; if ({dbus.d_be, dbus.d_wr_data} !== {4'b0010, 32'hEFEF_EFEF}) begin n_fail++; $display("FAIL byte_store got %b/%h want 0010/efefefef", dbus.d_be, dbus.d_wr_data); end
    tick();
    n_tests++; if ({valid_wb, wr_en_wb, rd_data_wb} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL store_wb got %b%b/%h want 10/0", valid_wb, wr_en_wb, rd_data_wb); end
    clear_inputs();
    tick();
  endtask

  task automatic test_miss;
    int stalls;
    int bubbles;
    stalls = 0; bubbles = 0;
    set_acc(RD, WORD, 0, 32'h100, 32'h0);
    dbus.d_miss = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (stall_mem === 1'b1 && dbus.d_rd === 1'b1) stalls++;
      tick();
      if (valid_wb === 1'b0) bubbles++;
    end
    n_tests++; if (stalls != 3) begin n_fail++; $display("FAIL miss_stall_cycles got %0d want 3", stalls); end
    n_tests++; if (bubbles != 3) begin n_fail++; $display("FAIL miss_bubbles got %0d want 3", bubbles); end
    dbus.d_miss = 0; dbus.d_rd_data = 32'hCAFE_F00D;
    #1;
    n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL miss_release_stall got %b want 0", stall_mem); end
    tick();
    n_tests++; if ({valid_wb, rd_data_wb} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL miss_result got %b/%h want 1/cafef00d", valid_wb, rd_data_wb); end
    n_tests++; if (miss_cycles !== 4'd3) begin n_fail++; $display("FAIL miss_count got %0d want 3", miss_cycles); end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush;
    set_acc(RD, WORD, 0, 32'h300, 32'h0);
    dbus.d_miss = 1;
    tick();
    flushMEM = 1;
    #1;
    n_tests++; if ({dbus.d_rd, dbus.d_be, stall_mem} !== 6'b0) begin n_fail++; $display("FAIL flush_strobes got %b want 0", {dbus.d_rd, dbus.d_be, stall_mem}); end
    tick();
    n_tests++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL flush_bubble got %b want 0", valid_wb); end
    n_tests++; if (miss_cycles !== 4'd4) begin n_fail++; $display("FAIL flush_count got %0d want 4", miss_cycles); end
    clear_inputs();
    tick();
    n_tests++; if ({valid_wb, miss_cycles} !== {1'b0, 4'd4}) begin n_fail++; $display("FAIL flush_idle got %b/%0d want 0/4", valid_wb, miss_cycles); end
    set_acc(RD, WORD, 0, 32'h304, 32'h0);
    dbus.d_rd_data = 32'h0BAD_CAFE;
    tick();
    n_tests++; if ({valid_wb, rd_data_wb} !== {1'b1, 32'h0BAD_CAFE}) begin n_fail++; $display("FAIL post_flush_hit got %b/%h want 1/0badcafe", valid_wb, rd_data_wb); end
    clear_inputs();
  endtask

  task automatic test_misalign;
    set_acc(RD, WORD, 0, 32'h102, 32'h0);
    dbus.d_miss = 1;
    #1;
    n_tests++; if ({dbus.d_rd, dbus.d_wr, dbus.d_be, stall_mem} !== 7'b0) begin n_fail++; $display("FAIL misalign_word_strobes got %b want 0", {dbus.d_rd, dbus.d_wr, dbus.d_be, stall_mem}); end
    tick();
    n_tests++; if ({valid_wb, misalign_wb, wr_en_wb} !== 3'b110) begin n_fail++; $display("FAIL misalign_word_wb got %b want 110", {valid_wb, misalign_wb, wr_en_wb}); end
    set_acc(WR, HALF, 0, 32'h101, 32'h5555);
    #1;
    n_tests++; if (dbus.d_wr !== 1'b0) begin n_fail++; $display("FAIL misalign_half_wr got %b want 0", dbus.d_wr); end
    tick();
    n_tests++; if ({valid_wb, misalign_wb} !== 2'b11) begin n_fail++; $display("FAIL misalign_half_wb got %b want 11", {valid_wb, misalign_wb}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_saturate_and_reset;
    set_acc(RD, WORD, 0, 32'h400, 32'h0);
    dbus.d_miss = 1;
    repeat (20) tick();
    n_tests++; if (miss_cycles !== 4'hF) begin n_fail++; $display("FAIL sat_count got %0d want 15", miss_cycles); end
    #2;
    rst_n = 0;
    #1;
    n_tests++; if ({dbus.d_rd, stall_mem, dbus.d_be, dbus.d_addr} !== 38'b0) begin n_fail++; $display("FAIL async_reset_bus got %b%b/%b/%h want 0", dbus.d_rd, stall_mem, dbus.d_be, dbus.d_addr); end
    n_tests++; if ({valid_wb, miss_cycles} !== 5'b0) begin n_fail++; $display("FAIL async_reset_state got %b/%0d want 0/0", valid_wb, miss_cycles); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    set_acc(RD, WORD, 0, 32'h404, 32'h0);
    dbus.d_rd_data = 32'h1357_9BDF;
    tick();
    n_tests++; if ({valid_wb, rd_data_wb, miss_cycles} !== {1'b1, 32'h1357_9BDF, 4'd0}) begin n_fail++; $display("FAIL reset_to_idle got %b/%h/%0d want 1/13579bdf/0", valid_wb, rd_data_wb, miss_cycles); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_half_load();
    test_store();
    test_miss();
    test_flush();
    test_misalign();
    test_saturate_and_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
